// File: rtl/kbd_hex_history_if.sv
// Keyboard-side bus for the hex history display: decoded ASCII strobe and
// modifiers in, seven-segment digits and status out.
interface kbd_hex_history_if #(
    parameter int NBYTES = 3
);
    logic                  data_valid;
    logic [7:0]            data;
    logic                  shift;
    logic                  is_caps;
    logic                  clear;
    logic                  en;
    logic [14*NBYTES-1:0]  hex_out;
    logic [7:0]            last_ascii;
    logic [7:0]            key_count;

    modport master (
        output data_valid, data, shift, is_caps, clear, en,
        input  hex_out, last_ascii, key_count
    );

    modport slave (
        input  data_valid, data, shift, is_caps, clear, en,
        output hex_out, last_ascii, key_count
    );
endinterface

// File: rtl/kbd_hex_history.sv
// Keyboard-to-seven-segment history display: shift/caps upper-casing, NBYTES
// deep byte history, newest-pair flash on capture and a keystroke counter.
module kbd_hex_history #(
    parameter int NBYTES       = 3,
    parameter int FLASH_CYCLES = 5000000
) (
    input logic              clk,
    input logic              rst,
    kbd_hex_history_if.slave bus
);
    localparam int FW = $clog2(FLASH_CYCLES + 1);

    logic [7:0]           hist [NBYTES];
    logic [NBYTES-1:0]    vld;
    logic [7:0]           key_count;
    logic [FW-1:0]        flash_cnt;
    logic                 upper;
    logic                 is_letter;
    logic [7:0]           conv_byte;
    logic [14*NBYTES-1:0] hex_v;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Only lower-case letters are ever folded; everything else passes through.
    always_comb begin
        upper     = bus.shift ^ bus.is_caps;
        is_letter = (bus.data >= 8'h61) && (bus.data <= 8'h7A);
        conv_byte = (upper && is_letter) ? (bus.data - 8'h20) : bus.data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBYTES; i++) hist[i] <= 8'h00;
            vld       <= '0;
            key_count <= 8'h00;
            flash_cnt <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < NBYTES; i++) hist[i] <= 8'h00;
            vld       <= '0;
            key_count <= 8'h00;
            flash_cnt <= '0;
        end else if (bus.data_valid) begin
            for (int i = NBYTES - 1; i > 0; i--) begin
                hist[i] <= hist[i-1];
                vld[i]  <= vld[i-1];
            end
            hist[0]   <= conv_byte;
            vld[0]    <= 1'b1;
            key_count <= key_count + 8'd1;
            flash_cnt <= FW'(FLASH_CYCLES);
        end else if (flash_cnt != '0) begin
            flash_cnt <= flash_cnt - FW'(1);
        end
    end

    // Blanking order: display disable, then never-written slot, then the flash on pair 0.
    always_comb begin
        hex_v = '1;
        for (int i = 0; i < NBYTES; i++) begin
            if (bus.en && vld[i] && !((i == 0) && (flash_cnt != '0))) begin
                hex_v[14*i +: 7]     = seg7(hist[i][3:0]);
                hex_v[14*i + 7 +: 7] = seg7(hist[i][7:4]);
            end
        end
    end

    assign bus.hex_out    = hex_v;
    assign bus.last_ascii = hist[0];
    assign bus.key_count  = key_count;
endmodule

// File: tb/tb_kbd_hex_history.sv
// Self-checking bench for kbd_hex_history: directed scenarios plus random
// traffic compared against a queue-based model of the visible history.
module tb_kbd_hex_history;
    localparam int NB = 3;
    localparam int F  = 4;
    localparam int HW = 14 * NB;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       dv   = 1'b0;
    logic [7:0] d    = 8'h00;
    logic       sh   = 1'b0;
    logic       cp   = 1'b0;
    logic       cl   = 1'b0;
    logic       en_r = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: newest byte at q[0]; since = edges elapsed since the last capture.
    logic [7:0] q[$];
    int         count = 0;
    int         since = F;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    kbd_hex_history_if #(.NBYTES(NB)) bus ();

    assign bus.data_valid = dv;
    assign bus.data       = d;
    assign bus.shift      = sh;
    assign bus.is_caps    = cp;
    assign bus.clear      = cl;
    assign bus.en         = en_r;

    kbd_hex_history #(.NBYTES(NB), .FLASH_CYCLES(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        count = 0;
        since = F;
    endtask

    task automatic model_edge();
        logic [7:0] b;
        if (cl) begin
            model_reset();
        end else if (dv) begin
            b = d;
            if ((sh != cp) && d >= "a" && d <= "z") b = d - 8'd32;
            q.push_front(b);
            if (q.size() > NB) void'(q.pop_back());
            count = (count + 1) % 256;
            since = 0;
        end else if (since < F) begin
            since++;
        end
    endtask

    function automatic logic [HW-1:0] exp_hex();
        logic [HW-1:0] h;
        logic [7:0]    b;
        h = '1;
        for (int i = 0; i < NB; i++) begin
            if (en_r && i < q.size() && !(i == 0 && since < F)) begin
                b = q[i];
                h[14*i +: 7]     = seg_tab[b[3:0]];
                h[14*i + 7 +: 7] = seg_tab[b[7:4]];
            end
        end
        return h;
    endfunction

    function automatic logic [7:0] exp_last();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (bus.hex_out !== {HW{1'b1}}) begin
            n_fail++; $display("[TB] FAIL reset_hex got %h expected %h", bus.hex_out, {HW{1'b1}});
        end
        n_checks++;
        if (bus.last_ascii !== 8'h00) begin
            n_fail++; $display("[TB] FAIL reset_last got %h expected 00", bus.last_ascii);
        end
        n_checks++;
        if (bus.key_count !== 8'h00) begin
            n_fail++; $display("[TB] FAIL reset_count got %h expected 00", bus.key_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (bus.hex_out !== exp_hex()) begin
                n_fail++; $display("[TB] FAIL idle_hex got %h expected %h", bus.hex_out, exp_hex());
            end
        end
    endtask

    task automatic test_capture_shift();
        dv = 1'b1; d = 8'h61; sh = 1'b1; cp = 1'b0;
        tick();
        dv = 1'b0; sh = 1'b0;
        n_checks++;
        if (bus.last_ascii !== 8'h41) begin
            n_fail++; $display("[TB] FAIL shift_last got %h expected 41", bus.last_ascii);
        end
        for (int c = 0; c < F + 1; c++) begin
            n_checks++;
            if (bus.hex_out !== exp_hex()) begin
                n_fail++; $display("[TB] FAIL shift_flash_hex cyc %0d got %h expected %h", c, bus.hex_out, exp_hex());
            end
            if (c == F - 1) begin
                n_checks++;
                if (bus.hex_out[13:0] !== {14{1'b1}}) begin
                    n_fail++; $display("[TB] FAIL flash_last_blank got %h expected 3fff", bus.hex_out[13:0]);
                end
            end
            if (c < F) tick();
        end
        n_checks++;
        if (bus.hex_out !== {28'hFFFFFFF, 7'h19, 7'h79}) begin
            n_fail++; $display("[TB] FAIL shift_shown got %h expected %h", bus.hex_out, {28'hFFFFFFF, 7'h19, 7'h79});
        end
        n_checks++;
        if (bus.key_count !== 8'h01) begin
            n_fail++; $display("[TB] FAIL shift_count got %h expected 01", bus.key_count);
        end
    endtask

    task automatic test_caps_cancel();
        dv = 1'b1; d = 8'h61; sh = 1'b1; cp = 1'b1;
        tick();
        dv = 1'b0;
        n_checks++;
        if (bus.last_ascii !== 8'h61) begin
            n_fail++; $display("[TB] FAIL caps_last got %h expected 61", bus.last_ascii);
        end
        for (int c = 0; c < F; c++) tick();
        n_checks++;
        if (bus.hex_out[13:0] !== {7'h02, 7'h79}) begin
            n_fail++; $display("[TB] FAIL caps_pair0 got %h expected %h", bus.hex_out[13:0], {7'h02, 7'h79});
        end
        dv = 1'b1; d = 8'h31; sh = 1'b1; cp = 1'b0;
        tick();
        dv = 1'b0; sh = 1'b0;
        n_checks++;
        if (bus.last_ascii !== 8'h31) begin
            n_fail++; $display("[TB] FAIL digit_last got %h expected 31", bus.last_ascii);
        end
        n_checks++;
        if (bus.hex_out !== exp_hex()) begin
            n_fail++; $display("[TB] FAIL digit_hex got %h expected %h", bus.hex_out, exp_hex());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        cl = 1'b1;
        tick();
        cl = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dv = 1'b1; d = seq[k];
            tick();
        end
        dv = 1'b0;
        for (int c = 0; c < F; c++) begin
            n_checks++;
            if (bus.hex_out !== exp_hex()) begin
                n_fail++; $display("[TB] FAIL b2b_hex cyc %0d got %h expected %h", c, bus.hex_out, exp_hex());
            end
            tick();
        end
        n_checks++;
        if (bus.hex_out !== {7'h24, 7'h24, 7'h30, 7'h30, 7'h19, 7'h19}) begin
            n_fail++; $display("[TB] FAIL b2b_shown got %h expected %h", bus.hex_out, {7'h24, 7'h24, 7'h30, 7'h30, 7'h19, 7'h19});
        end
        n_checks++;
        if (bus.key_count !== 8'h04) begin
            n_fail++; $display("[TB] FAIL b2b_count got %h expected 04", bus.key_count);
        end
    endtask

    task automatic test_wrap_and_clear();
        cl = 1'b1;
        tick();
        cl = 1'b0;
        for (int k = 0; k < 256; k++) begin
            dv = 1'b1; d = 8'($urandom_range(0, 255)); sh = 1'($urandom); cp = 1'($urandom);
            tick();
            if (k == 254) begin
                n_checks++;
                if (bus.key_count !== 8'hFF) begin
                    n_fail++; $display("[TB] FAIL wrap_255 got %h expected ff", bus.key_count);
                end
            end
        end
        n_checks++;
        if (bus.key_count !== 8'h00) begin
            n_fail++; $display("[TB] FAIL wrap_count got %h expected 00", bus.key_count);
        end
        n_checks++;
        if (bus.last_ascii !== exp_last()) begin
            n_fail++; $display("[TB] FAIL wrap_last got %h expected %h", bus.last_ascii, exp_last());
        end
        dv = 1'b1; cl = 1'b1; d = 8'h5A;
        tick();
        dv = 1'b0; cl = 1'b0;
        n_checks++;
        if (bus.hex_out !== {HW{1'b1}} || bus.key_count !== 8'h00 || bus.last_ascii !== 8'h00) begin
            n_fail++; $display("[TB] FAIL clear_prio got hex %h cnt %h last %h expected all-blank 00 00",
                               bus.hex_out, bus.key_count, bus.last_ascii);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            dv   = ($urandom_range(0, 2) == 0);
            d    = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h5E, 8'h7D)) : 8'($urandom_range(0, 255));
            sh   = 1'($urandom);
            cp   = 1'($urandom);
            cl   = ($urandom_range(0, 60) == 0);
            en_r = ($urandom_range(0, 4) != 0);
            tick();
            n_checks++;
            if (bus.hex_out !== exp_hex()) begin
                n_fail++; $display("[TB] FAIL rand_hex cyc %0d got %h expected %h", c, bus.hex_out, exp_hex());
            end
            n_checks++;
            if (bus.last_ascii !== exp_last()) begin
                n_fail++; $display("[TB] FAIL rand_last cyc %0d got %h expected %h", c, bus.last_ascii, exp_last());
            end
            n_checks++;
            if (bus.key_count !== 8'(count)) begin
                n_fail++; $display("[TB] FAIL rand_count cyc %0d got %h expected %h", c, bus.key_count, 8'(count));
            end
        end
        dv = 1'b0; cl = 1'b0; en_r = 1'b1;
    endtask

    task automatic test_enable();
        int start;
        start = count;
        en_r = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dv = 1'b1; d = 8'($urandom_range(0, 255));
            tick();
        end
        dv = 1'b0;
        for (int c = 0; c < F; c++) tick();
        n_checks++;
        if (bus.hex_out !== {HW{1'b1}}) begin
            n_fail++; $display("[TB] FAIL en_blank got %h expected all ones", bus.hex_out);
        end
        n_checks++;
        if (bus.key_count !== 8'(start + 3)) begin
            n_fail++; $display("[TB] FAIL en_count got %h expected %h", bus.key_count, 8'(start + 3));
        end
        en_r = 1'b1;
        #1;
        n_checks++;
        if (bus.hex_out !== exp_hex() || exp_hex() === {HW{1'b1}}) begin
            n_fail++; $display("[TB] FAIL en_show got %h expected %h", bus.hex_out, exp_hex());
        end
    endtask

    task automatic test_async_reset_midflash();
        dv = 1'b1; d = 8'h7A; sh = 1'b0; cp = 1'b1;
        tick();
        dv = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (bus.hex_out !== {HW{1'b1}} || bus.last_ascii !== 8'h00 || bus.key_count !== 8'h00) begin
            n_fail++; $display("[TB] FAIL async_rst got hex %h last %h cnt %h expected blank 00 00",
                               bus.hex_out, bus.last_ascii, bus.key_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < F + 1; c++) begin
            tick();
            n_checks++;
            if (bus.hex_out !== exp_hex() || bus.key_count !== 8'(count)) begin
                n_fail++; $display("[TB] FAIL post_rst cyc %0d got hex %h cnt %h expected %h %h",
                                   c, bus.hex_out, bus.key_count, exp_hex(), 8'(count));
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture_shift();
        test_caps_cancel();
        test_back_to_back();
        test_wrap_and_clear();
        test_random();
        test_enable();
        test_async_reset_midflash();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
